// File: rtl/lcd_text_driver.sv
// HD44780 8-bit parallel driver: power-up delay, four-command init, then 0x80 plus 16 characters of line 1.
// Optional macro LCD_REFRESH_ON_CHANGE_EN: idle after each frame and redraw only when an input byte changes.
module lcd_text_driver #(
    parameter int POWERUP_CYC    = 2000000,
    parameter int SETUP_CYC      = 4,
    parameter int EN_PULSE_CYC   = 12,
    parameter int CMD_WAIT_CYC   = 2500,
    parameter int CLEAR_WAIT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] d000,
    input  logic [7:0] d001,
    input  logic [7:0] d002,
    input  logic [7:0] d003,
    input  logic [7:0] d004,
    input  logic [7:0] d005,
    input  logic [7:0] d006,
    input  logic [7:0] d007,
    input  logic [7:0] d008,
    input  logic [7:0] d009,
    input  logic [7:0] d010,
    input  logic [7:0] d011,
    input  logic [7:0] d012,
    input  logic [7:0] d013,
    input  logic [7:0] d014,
    input  logic [7:0] d015,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic       init_done,
    output logic       frame_done
);

    localparam int MAX_A   = (POWERUP_CYC > SETUP_CYC) ? POWERUP_CYC : SETUP_CYC;
    localparam int MAX_B   = (MAX_A > EN_PULSE_CYC) ? MAX_A : EN_PULSE_CYC;
    localparam int MAX_C   = (MAX_B > CMD_WAIT_CYC) ? MAX_B : CMD_WAIT_CYC;
    localparam int MAX_CYC = (MAX_C > CLEAR_WAIT_CYC) ? MAX_C : CLEAR_WAIT_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(POWERUP_CYC - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(EN_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLEAR_WAIT_CYC - 1);

    // Steps 0..3 are the init commands, 4 is the DDRAM address, 5..20 are the characters.
    localparam logic [4:0] STEP_CLEAR      = 5'd3;
    localparam logic [4:0] STEP_ADDR       = 5'd4;
    localparam logic [4:0] STEP_FIRST_CHAR = 5'd5;
    localparam logic [4:0] STEP_LAST       = 5'd20;

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_SETUP,
        ST_PULSE,
        ST_WAIT,
        ST_DONE,
        ST_IDLE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [CNT_W-1:0] wait_last;
    logic [4:0]       idx;
    logic [4:0]       idx_nx;
    logic [127:0]     din;
    logic [127:0]     snap;
    logic [3:0]       char_sel;
    logic [7:0]       data_nx;
    logic             rs_nx;
    logic             start_xfer;
    logic             clear_end;

    assign din = {d015, d014, d013, d012, d011, d010, d009, d008,
                  d007, d006, d005, d004, d003, d002, d001, d000};

    assign lcd_rw     = 1'b0;
    assign wait_last  = (idx == STEP_CLEAR) ? CLR_LAST : CMD_LAST;
    assign start_xfer = (state_nx == ST_SETUP) && (state != ST_SETUP);
    assign clear_end  = (state == ST_WAIT) && (state_nx != ST_WAIT) && (idx == STEP_CLEAR);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        idx_nx   = idx;
        case (state)
            ST_POWERUP: begin
                if (cnt == PWR_LAST) begin
                    state_nx = ST_SETUP;
                    cnt_nx   = '0;
                    idx_nx   = 5'd0;
                end
            end
            ST_SETUP: begin
                if (cnt == SETUP_LAST) begin
                    state_nx = ST_PULSE;
                    cnt_nx   = '0;
                end
            end
            ST_PULSE: begin
                if (cnt == PULSE_LAST) begin
                    state_nx = ST_WAIT;
                    cnt_nx   = '0;
                end
            end
            ST_WAIT: begin
                if (cnt == wait_last) begin
                    cnt_nx = '0;
                    if (idx == STEP_LAST) begin
                        state_nx = ST_DONE;
                    end else begin
                        state_nx = ST_SETUP;
                        idx_nx   = idx + 5'd1;
                    end
                end
            end
            // frame_done is high for exactly this one cycle
            ST_DONE: begin
                cnt_nx = '0;
`ifdef LCD_REFRESH_ON_CHANGE_EN
                state_nx = ST_IDLE;
`else
                state_nx = ST_SETUP;
                idx_nx   = STEP_ADDR;
`endif
            end
            ST_IDLE: begin
                cnt_nx = '0;
                if (din != snap) begin
                    state_nx = ST_SETUP;
                    idx_nx   = STEP_ADDR;
                end
            end
            default: begin
                state_nx = ST_POWERUP;
                cnt_nx   = '0;
                idx_nx   = 5'd0;
            end
        endcase
    end

    // Byte and register-select for the transfer about to begin; characters come only from the snapshot.
    always_comb begin
        char_sel = 4'(idx_nx - STEP_FIRST_CHAR);
        rs_nx    = (idx_nx >= STEP_FIRST_CHAR);
        data_nx  = 8'h00;
        case (idx_nx)
            5'd0:    data_nx = 8'h38;
            5'd1:    data_nx = 8'h0C;
            5'd2:    data_nx = 8'h06;
            5'd3:    data_nx = 8'h01;
            5'd4:    data_nx = 8'h80;
            default: data_nx = snap[{char_sel, 3'b000} +: 8];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_POWERUP;
            cnt        <= '0;
            idx        <= 5'd0;
            snap       <= '0;
            lcd_data   <= 8'h00;
            lcd_rs     <= 1'b0;
            lcd_e      <= 1'b0;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            idx        <= idx_nx;
            lcd_e      <= (state_nx == ST_PULSE);
            frame_done <= (state_nx == ST_DONE);
            if (start_xfer) begin
                lcd_data <= data_nx;
                lcd_rs   <= rs_nx;
            end
            // The address transfer's first cycle freezes the frame contents
            if (start_xfer && (idx_nx == STEP_ADDR)) begin
                snap <= din;
            end
            if (clear_end) begin
                init_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_text_driver.sv
// Self-checking bench for lcd_text_driver: timing of every E strobe is predicted from the transfer arithmetic.
// Build with LCD_REFRESH_ON_CHANGE_EN defined to exercise the refresh-on-change behaviour instead.
module tb_lcd_text_driver;

    localparam int PW        = 10;
    localparam int S         = 2;
    localparam int P         = 3;
    localparam int CW        = 5;
    localparam int CLW       = 20;
    localparam int T         = S + P + CW;
    localparam int INIT_END  = PW + 3 * T + S + P + CLW;
    localparam int FRAME_LEN = 17 * T;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] d [16];
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic       init_done;
    logic       frame_done;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    int         rise_cyc_q[$];
    logic [7:0] rise_data_q[$];
    logic       rise_rs_q[$];
    logic [7:0] fall_data_q[$];
    int         width_q[$];
    int         done_q[$];
    int         init_rise_q[$];
    logic       e_prev  = 1'b0;
    logic       id_prev = 1'b0;
    int         hi_cnt  = 0;

    lcd_text_driver #(
        .POWERUP_CYC   (PW),
        .SETUP_CYC     (S),
        .EN_PULSE_CYC  (P),
        .CMD_WAIT_CYC  (CW),
        .CLEAR_WAIT_CYC(CLW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .d000      (d[0]),
        .d001      (d[1]),
        .d002      (d[2]),
        .d003      (d[3]),
        .d004      (d[4]),
        .d005      (d[5]),
        .d006      (d[6]),
        .d007      (d[7]),
        .d008      (d[8]),
        .d009      (d[9]),
        .d010      (d[10]),
        .d011      (d[11]),
        .d012      (d[12]),
        .d013      (d[13]),
        .d014      (d[14]),
        .d015      (d[15]),
        .lcd_data  (lcd_data),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_e     (lcd_e),
        .init_done (init_done),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Cycle number = count of rising edges since reset release
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (rst) begin
            e_prev  = 1'b0;
            id_prev = 1'b0;
            hi_cnt  = 0;
        end else begin
            if (lcd_e && !e_prev) begin
                rise_cyc_q.push_back(cyc);
                rise_data_q.push_back(lcd_data);
                rise_rs_q.push_back(lcd_rs);
                hi_cnt = 1;
            end else if (lcd_e) begin
                hi_cnt = hi_cnt + 1;
            end else if (e_prev) begin
                fall_data_q.push_back(lcd_data);
                width_q.push_back(hi_cnt);
            end
            if (frame_done) done_q.push_back(cyc);
            if (init_done && !id_prev) init_rise_q.push_back(cyc);
            e_prev  = lcd_e;
            id_prev = init_done;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [127:0] v);
        for (int i = 0; i < 16; i++) d[i] = v[8*i +: 8];
    endtask

    function automatic logic [127:0] str2vec(input string s);
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[8*i +: 8] = (i < s.len()) ? s[i] : 8'h20;
        return v;
    endfunction

    task automatic waitCycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic clearQueues();
        rise_cyc_q.delete();
        rise_data_q.delete();
        rise_rs_q.delete();
        fall_data_q.delete();
        width_q.delete();
        done_q.delete();
        init_rise_q.delete();
    endtask

    task automatic expectXfer(input string tag, input int exp_cyc, input logic [7:0] exp_data, input logic exp_rs);
        int n;
        n = 0;
        while (width_q.size() == 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (width_q.size() == 0 || rise_cyc_q.size() == 0) begin
            checkOutput({tag, " strobe_seen"}, width_q.size(), 1);
            return;
        end
        checkOutput({tag, " rise_cycle"}, rise_cyc_q.pop_front(), exp_cyc);
        checkOutput({tag, " data"}, rise_data_q.pop_front(), exp_data);
        checkOutput({tag, " rs"}, rise_rs_q.pop_front(), exp_rs);
        checkOutput({tag, " data_at_fall"}, fall_data_q.pop_front(), exp_data);
        checkOutput({tag, " e_width"}, width_q.pop_front(), P);
    endtask

    task automatic checkInit(input string tag);
        logic [7:0] cmds [4];
        int         start;
        cmds[0] = 8'h38;
        cmds[1] = 8'h0C;
        cmds[2] = 8'h06;
        cmds[3] = 8'h01;
        for (int k = 0; k < 4; k++) begin
            start = PW + k * T;
            expectXfer($sformatf("%s cmd%0d", tag, k), start + S, cmds[k], 1'b0);
        end
    endtask

    // Transfer j of a frame: j=0 is the 0x80 address, j>=1 is column j-1 of the latched vector
    task automatic checkFrame(input string tag, input int start, input logic [127:0] vec, input int j_lo, input int j_hi);
        for (int j = j_lo; j <= j_hi; j++) begin
            logic [7:0] b;
            if (j == 0) b = 8'h80;
            else        b = vec[8*(j-1) +: 8];
            expectXfer($sformatf("%s j%0d", tag, j), start + j * T + S, b, j != 0);
        end
    endtask

    initial begin
        logic [127:0] v_carr;
        logic [127:0] v_next;
        logic [7:0]   b;
        int           f_start;
        int           n;

        v_carr = str2vec("CARREGANDO!");
        applyStimulus(v_carr);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst lcd_data", lcd_data, 8'h00);
        checkOutput("rst lcd_rs", lcd_rs, 1'b0);
        checkOutput("rst lcd_rw", lcd_rw, 1'b0);
        checkOutput("rst lcd_e", lcd_e, 1'b0);
        checkOutput("rst init_done", init_done, 1'b0);
        checkOutput("rst frame_done", frame_done, 1'b0);

        rst = 1'b0;
        waitCycle(PW - 1);
        checkOutput("powerup lcd_data", lcd_data, 8'h00);
        checkOutput("powerup lcd_e", lcd_e, 1'b0);
        checkOutput("powerup lcd_rs", lcd_rs, 1'b0);

        checkInit("init");
        checkFrame("f0", INIT_END, v_carr, 0, 16);
        checkOutput("init_done rises", init_rise_q.size(), 1);
        if (init_rise_q.size() > 0) checkOutput("init_done cycle", init_rise_q[0], INIT_END);

`ifdef LCD_REFRESH_ON_CHANGE_EN
        waitCycle(INIT_END + FRAME_LEN + 1000);
        checkOutput("idle strobes", rise_cyc_q.size(), 0);
        checkOutput("idle lcd_e", lcd_e, 1'b0);
        checkOutput("idle lcd_data", lcd_data, 8'h20);
        checkOutput("idle lcd_rs", lcd_rs, 1'b1);
        checkOutput("idle frame_done count", done_q.size(), 1);
        if (done_q.size() > 0) checkOutput("f0 frame_done cycle", done_q[0], INIT_END + FRAME_LEN);

        b = 8'($urandom_range(32, 126));
        if (b == v_carr[63:56]) b = b + 8'd1;
        v_next         = v_carr;
        v_next[63:56]  = b;
        applyStimulus(v_next);
        f_start = cyc + 1;
        checkFrame("f1", f_start, v_next, 0, 6);
`else
        f_start = INIT_END + FRAME_LEN + 1;
        checkFrame("f1a", f_start, v_carr, 0, 4);
        waitCycle(f_start + 5 * T + S + 1);
        v_next = str2vec("CAIXA CHEIA!");
        applyStimulus(v_next);
        checkFrame("f1b", f_start, v_carr, 5, 16);

        f_start = f_start + FRAME_LEN + 1;
        checkFrame("f2a", f_start, v_next, 0, 8);
        waitCycle(f_start + 9 * T);
        b = 8'h00;
        for (int i = 0; i < 8; i++) v_next[8*i +: 8] = 8'($urandom_range(32, 126));
        for (int i = 8; i < 16; i++) v_next[8*i +: 8] = 8'($urandom_range(32, 126));
        applyStimulus(v_next);
        checkFrame("f2b", f_start, str2vec("CAIXA CHEIA!"), 9, 16);

        f_start = f_start + FRAME_LEN + 1;
        checkFrame("f3", f_start, v_next, 0, 6);
        checkOutput("frame_done count", done_q.size(), 3);
        for (int i = 0; i < 3 && i < done_q.size(); i++)
            checkOutput($sformatf("frame_done cycle f%0d", i), done_q[i], INIT_END + i * (FRAME_LEN + 1) + FRAME_LEN);
        checkOutput("frame_done low", frame_done, b[0]);
`endif

        // Async reset while the strobe is high
        n = 0;
        while (!lcd_e && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("e high before reset", lcd_e, 1'b1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async rst lcd_e", lcd_e, 1'b0);
        checkOutput("async rst lcd_rs", lcd_rs, 1'b0);
        checkOutput("async rst init_done", init_done, 1'b0);
        checkOutput("async rst lcd_data", lcd_data, 8'h00);
        repeat (2) @(negedge clk);
        clearQueues();
        rst = 1'b0;

        waitCycle(PW / 2);
        checkOutput("re-powerup lcd_e", lcd_e, 1'b0);
        checkInit("reinit");
        checkFrame("rf0", INIT_END, v_next, 0, 2);
        checkOutput("reinit init_done cycle", (init_rise_q.size() > 0) ? init_rise_q[0] : -1, INIT_END);
        checkOutput("final lcd_rw", lcd_rw, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lcd_text_driver.md
# lcd_text_driver

Sequential HD44780-compatible character LCD driver. Consumes the sixteen 8-bit ASCII character bytes produced by the message-selection logic (`d000`..`d015`, left to right) and writes them to line 1 of a 16x2 LCD through an 8-bit parallel bus. It owns the power-up delay, the controller initialisation sequence and the per-transfer E-strobe timing, so the message logic stays purely combinational.

## Interface
Parameters:
- `POWERUP_CYC`, 2000000: idle cycles after reset before the first transfer (40 ms at 50 MHz).
- `SETUP_CYC`, 4: cycles with RS/data valid and E low before the E rise.
- `EN_PULSE_CYC`, 12: cycles with E high.
- `CMD_WAIT_CYC`, 2500: cycles with E low after the E fall, for every transfer except clear.
- `CLEAR_WAIT_CYC`, 100000: cycles with E low after the E fall of the clear command (0x01).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `d000`..`d015`  in  8 each  ASCII characters for columns 0..15.
- `lcd_data`  out  8  LCD DB7..DB0.
- `lcd_rs`  out  1  0 = command, 1 = character data.
- `lcd_rw`  out  1  tied 0; write-only.
- `lcd_e`  out  1  enable strobe.
- `init_done`  out  1  high once the init sequence completes; stays high until reset.
- `frame_done`  out  1  one-cycle pulse after the 16th character's wait phase ends.

## Operation
- Reset values: `lcd_data`=0x00, `lcd_rs`=0, `lcd_rw`=0, `lcd_e`=0, `init_done`=0, `frame_done`=0. Internal counters and the snapshot buffer clear to 0.
- States: POWERUP -> INIT (4 commands) -> FRAME (1 command + 16 characters) -> IDLE/FRAME.
- POWERUP waits `POWERUP_CYC` cycles with all outputs at their reset values.
- INIT issues, with RS=0, the commands 0x38 (8-bit, 2 lines, 5x8), 0x0C (display on, cursor off), 0x06 (increment, no shift) and 0x01 (clear), in that order. `init_done` rises in the cycle after the clear's wait phase ends.
- FRAME issues 0x80 (DDRAM address 0) with RS=0, then `d000`..`d015` with RS=1.
- On the first cycle of the 0x80 transfer, all 16 inputs are latched into a 128-bit snapshot. Characters are driven from the snapshot only. Input changes mid-frame appear in the next frame, never mixed into the current one.
- Each transfer has three phases:
  - A: `SETUP_CYC` cycles, E=0.
  - B: `EN_PULSE_CYC` cycles, E=1.
  - C: `CMD_WAIT_CYC` cycles, or `CLEAR_WAIT_CYC` for 0x01, with E=0.
  - `lcd_data` and `lcd_rs` are constant across all three phases and change only on the first cycle of phase A.
- After the last character, `frame_done` pulses and the next state follows the configuration described below.
- Between transfers, `lcd_data`/`lcd_rs` hold their last values.

## Timing
- All outputs are registered; no combinational path from the inputs to the outputs.
- One transfer lasts S+P+W cycles, where S=`SETUP_CYC`, P=`EN_PULSE_CYC` and W is the phase-C length; phases are back to back with no gap cycles.
- First E rise occurs `POWERUP_CYC`+`SETUP_CYC` cycles after reset deassertion, with `lcd_data`=0x38.
- A frame lasts 17*(S+P+`CMD_WAIT_CYC`) cycles.
- A reset asserted mid-transfer forces `lcd_e` low asynchronously; the driver restarts at POWERUP, including a full re-init.
- The phase counter is sized to hold the largest parameter value; all parameters are at least 1.

## Configuration
- `LCD_REFRESH_ON_CHANGE_EN` undefined:
  - After `frame_done`, the next frame's 0x80 transfer starts on the following cycle.
  - Frames repeat continuously.
- `LCD_REFRESH_ON_CHANGE_EN` defined:
  - After `frame_done`, the driver enters IDLE: outputs held, E=0.
  - It compares the inputs with the snapshot every cycle.
  - The first cycle any byte differs starts a new frame on the next cycle.
  - The first frame after init is always sent.

## Test plan
Bench parameters: POWERUP=10, SETUP=2, EN_PULSE=3, CMD_WAIT=5, CLEAR_WAIT=20.
- Reset -> all outputs 0 during POWERUP; first E rise at cycle 12 after reset release, `lcd_data`=0x38, RS=0; E high for exactly 3 cycles.
- Reset, inputs "CARREGANDO!" plus 5 spaces (0x20) -> E-rise data sequence 38,0C,06,01,80,43,41,52,52,45,47,41,4E,44,4F,21,20,20,20,20,20; RS=1 only on the last 16; `init_done` rises after the 0x01 wait (20 cycles); `frame_done` pulses once.
- Inputs switched to "CAIXA CHEIA!" (43,41,49,58,41,20,43,48,45,49,41,21) during character 5 of a frame -> that frame completes with "CARREGANDO!"; the next frame carries "CAIXA CHEIA!".
- Reset asserted while E=1 mid-frame -> `lcd_e`, `lcd_rs` and `init_done` go to 0 immediately; after release, the full 0x38 init sequence repeats.
- Macro undefined, constant inputs -> the next frame's 0x80 E rise occurs SETUP+1 cycles after the `frame_done` pulse, and frames repeat back to back.
- Macro defined, constant inputs -> no E pulses after the first `frame_done` for 1000 cycles; changing `d007` -> a new frame starts 1 cycle after the change is sampled.
